rs_multi: RTL and testbench



---
 rtl/rs_multi_if.sv | 64 ++++++
 rtl/rs_multi.sv | 215 +++++++++++++++++++++
 tb/tb_rs_multi.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_multi_if.sv
// rs_multi_if: dispatch, CDB, issue-control and issued-lane bundle for the
// rs_multi reservation station.
//   master : dispatch / CDB / FU side (drives inputs, sees issued lanes)
//   slave  : the reservation station
// Signals: squash, CDB_{Data,PRF_idx,valid}, load_in, op{a,b}_{in,valid},
// {rd,wr}_mem_in, dest_PRF_idx_in, rob_idx_in, offset_in, PC_in,
// Operation_in, issue_en; issued lane fields *_out, inst_out_valid,
// num_is_free.
interface rs_multi_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned PW    = 6,
    parameter int unsigned RW    = 4,
    parameter int unsigned OLEN  = 16,
    parameter int unsigned PCLEN = 32,
    parameter int unsigned FW    = 5,
    parameter int unsigned WAYS  = 3,
    parameter int unsigned CW    = 5
);
    logic                        squash;
    logic [WAYS-1:0][XLEN-1:0]   CDB_Data;
    logic [WAYS-1:0][PW-1:0]     CDB_PRF_idx;
    logic [WAYS-1:0]             CDB_valid;
    logic [WAYS-1:0]             load_in;
    logic [WAYS-1:0][XLEN-1:0]   opa_in;
    logic [WAYS-1:0][XLEN-1:0]   opb_in;
    logic [WAYS-1:0]             opa_valid;
    logic [WAYS-1:0]             opb_valid;
    logic [WAYS-1:0]             rd_mem_in;
    logic [WAYS-1:0]             wr_mem_in;
    logic [WAYS-1:0][PW-1:0]     dest_PRF_idx_in;
    logic [WAYS-1:0][RW-1:0]     rob_idx_in;
    logic [WAYS-1:0][OLEN-1:0]   offset_in;
    logic [WAYS-1:0][PCLEN-1:0]  PC_in;
    logic [WAYS-1:0][FW-1:0]     Operation_in;
    logic [WAYS-1:0]             issue_en;

    logic [WAYS-1:0]             inst_out_valid;
    logic [WAYS-1:0][XLEN-1:0]   opa_out;
    logic [WAYS-1:0][XLEN-1:0]   opb_out;
    logic [WAYS-1:0][PW-1:0]     dest_PRF_idx_out;
    logic [WAYS-1:0][RW-1:0]     rob_idx_out;
    logic [WAYS-1:0][PCLEN-1:0]  PC_out;
    logic [WAYS-1:0][FW-1:0]     Operation_out;
    logic [WAYS-1:0][OLEN-1:0]   offset_out;
    logic [WAYS-1:0]             rd_mem_out;
    logic [WAYS-1:0]             wr_mem_out;
    logic [CW-1:0]               num_is_free;

    modport master (
        output squash, CDB_Data, CDB_PRF_idx, CDB_valid, load_in, opa_in, opb_in,
               opa_valid, opb_valid, rd_mem_in, wr_mem_in, dest_PRF_idx_in, rob_idx_in,
               offset_in, PC_in, Operation_in, issue_en,
        input  inst_out_valid, opa_out, opb_out, dest_PRF_idx_out, rob_idx_out, PC_out,
               Operation_out, offset_out, rd_mem_out, wr_mem_out, num_is_free
    );

    modport slave (
        input  squash, CDB_Data, CDB_PRF_idx, CDB_valid, load_in, opa_in, opb_in,
               opa_valid, opb_valid, rd_mem_in, wr_mem_in, dest_PRF_idx_in, rob_idx_in,
               offset_in, PC_in, Operation_in, issue_en,
        output inst_out_valid, opa_out, opb_out, dest_PRF_idx_out, rob_idx_out, PC_out,
               Operation_out, offset_out, rd_mem_out, wr_mem_out, num_is_free
    );
endinterface

// File: rtl/rs_multi.sv
// rs_multi: WAYS-wide reservation station with RS entries.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high, clears the station and the issue registers
//   bus    rs_multi_if.slave: dispatch, CDB wakeup, issue enables, registered
//          issue lanes and the free-entry count
// Dispatch takes set load_in bits MSB-first and fills free entries lowest index
// first. Issue lanes are also packed MSB-first, so instructions dispatched together
// come out with lane k carrying way k.
// Optional: `define RS_AGE_SELECT_EN picks the oldest ready entries (ties to lower
// index); otherwise lowest ready index wins.
module rs_multi #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned PRF   = 64,
    parameter int unsigned ROB   = 16,
    parameter int unsigned RS    = 16,
    parameter int unsigned WAYS  = 3,
    parameter int unsigned OLEN  = 16,
    parameter int unsigned PCLEN = 32,
    parameter int unsigned FW    = 5    // ALU_FUNC width
) (
    input logic       clock,
    input logic       reset,
    rs_multi_if.slave bus
);
    localparam int unsigned PW = $clog2(PRF);
    localparam int unsigned RW = $clog2(ROB);
    localparam int unsigned IW = $clog2(RS);
    localparam int unsigned CW = $clog2(RS) + 1;

    typedef struct packed {
        logic             rd_mem;
        logic             wr_mem;
        logic [PW-1:0]    dest;
        logic [RW-1:0]    rob;
        logic [OLEN-1:0]  offset;
        logic [PCLEN-1:0] pc;
        logic [FW-1:0]    op;
    } payload_t;

    // A not-ready operand holds its tag in the low PW bits of a/b.
    typedef struct packed {
        logic            valid;
        logic            a_rdy;
        logic            b_rdy;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        payload_t        p;
    } entry_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        payload_t        p;
    } lane_t;

    entry_t        ent_q  [RS];
    entry_t        ent_d  [RS];
    lane_t         lane_q [WAYS];
    lane_t         lane_d [WAYS];
`ifdef RS_AGE_SELECT_EN
    logic [IW-1:0] age_q  [RS];
    logic [IW-1:0] age_d  [RS];
`endif
    logic [CW-1:0] free_cnt;
    logic [RS-1:0] taken;
    logic [RS-1:0] used;
    logic          found;
    logic [IW-1:0] best;

    always_comb begin
        ent_d    = ent_q;
        free_cnt = '0;
        taken    = '0;
        used     = '0;
        found    = 1'b0;
        best     = '0;
        for (int l = 0; l < WAYS; l++) lane_d[l] = '0;
`ifdef RS_AGE_SELECT_EN
        age_d = age_q;
        for (int i = 0; i < RS; i++) begin
            if (ent_q[i].valid && age_q[i] != '1) age_d[i] = age_q[i] + IW'(1);
        end
`endif
        for (int i = 0; i < RS; i++) begin
            if (!ent_q[i].valid) free_cnt = free_cnt + CW'(1);
        end

        // Wakeup of waiting operands from the CDB.
        for (int i = 0; i < RS; i++) begin
            for (int c = 0; c < WAYS; c++) begin
                if (ent_q[i].valid && bus.CDB_valid[c]) begin
                    if (!ent_q[i].a_rdy && ent_q[i].a[PW-1:0] == bus.CDB_PRF_idx[c]) begin
                        ent_d[i].a     = bus.CDB_Data[c];
                        ent_d[i].a_rdy = 1'b1;
                    end
                    if (!ent_q[i].b_rdy && ent_q[i].b[PW-1:0] == bus.CDB_PRF_idx[c]) begin
                        ent_d[i].b     = bus.CDB_Data[c];
                        ent_d[i].b_rdy = 1'b1;
                    end
                end
            end
        end

        // Issue: each enabled lane, MSB first, takes the best remaining candidate.
        for (int l = WAYS - 1; l >= 0; l--) begin
            found = 1'b0;
            best  = '0;
            if (bus.issue_en[l]) begin
                for (int i = 0; i < RS; i++) begin
                    if (ent_q[i].valid && ent_q[i].a_rdy && ent_q[i].b_rdy && !taken[i]) begin
`ifdef RS_AGE_SELECT_EN
                        // Strictly older replaces, so ties keep the lower index.
                        if (!found || age_q[i] > age_q[best]) begin
`else
                        if (!found) begin
`endif
                            found = 1'b1;
                            best  = IW'(i);
                        end
                    end
                end
            end
            if (found) begin
                taken[best]       = 1'b1;
                ent_d[best].valid = 1'b0;
                lane_d[l].valid   = 1'b1;
                lane_d[l].a       = ent_q[best].a;
                lane_d[l].b       = ent_q[best].b;
                lane_d[l].p       = ent_q[best].p;
            end
        end

        // Dispatch into slots free at cycle start; issued slots are never reused here.
        for (int w = WAYS - 1; w >= 0; w--) begin
            found = 1'b0;
            best  = '0;
            if (bus.load_in[w]) begin
                for (int i = 0; i < RS; i++) begin
                    if (!ent_q[i].valid && !used[i] && !found) begin
                        found = 1'b1;
                        best  = IW'(i);
                    end
                end
            end
            if (found) begin
                used[best]          = 1'b1;
                ent_d[best].valid   = 1'b1;
                ent_d[best].a       = bus.opa_in[w];
                ent_d[best].a_rdy   = bus.opa_valid[w];
                ent_d[best].b       = bus.opb_in[w];
                ent_d[best].b_rdy   = bus.opb_valid[w];
                ent_d[best].p.rd_mem = bus.rd_mem_in[w];
                ent_d[best].p.wr_mem = bus.wr_mem_in[w];
                ent_d[best].p.dest   = bus.dest_PRF_idx_in[w];
                ent_d[best].p.rob    = bus.rob_idx_in[w];
                ent_d[best].p.offset = bus.offset_in[w];
                ent_d[best].p.pc     = bus.PC_in[w];
                ent_d[best].p.op     = bus.Operation_in[w];
                // Same-cycle CDB bypass for tag operands.
                for (int c = 0; c < WAYS; c++) begin
                    if (bus.CDB_valid[c]) begin
                        if (!bus.opa_valid[w] && bus.opa_in[w][PW-1:0] == bus.CDB_PRF_idx[c]) begin
                            ent_d[best].a     = bus.CDB_Data[c];
                            ent_d[best].a_rdy = 1'b1;
                        end
                        if (!bus.opb_valid[w] && bus.opb_in[w][PW-1:0] == bus.CDB_PRF_idx[c]) begin
                            ent_d[best].b     = bus.CDB_Data[c];
                            ent_d[best].b_rdy = 1'b1;
                        end
                    end
                end
`ifdef RS_AGE_SELECT_EN
                age_d[best] = '0;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || bus.squash) begin
            for (int i = 0; i < RS; i++) begin
                ent_q[i] <= '0;
`ifdef RS_AGE_SELECT_EN
                age_q[i] <= '0;
`endif
            end
            for (int l = 0; l < WAYS; l++) lane_q[l] <= '0;
        end else begin
            ent_q  <= ent_d;
            lane_q <= lane_d;
`ifdef RS_AGE_SELECT_EN
            age_q  <= age_d;
`endif
        end
    end

    always_comb begin
        for (int l = 0; l < WAYS; l++) begin
            bus.inst_out_valid[l]   = lane_q[l].valid;
            bus.opa_out[l]          = lane_q[l].a;
            bus.opb_out[l]          = lane_q[l].b;
            bus.dest_PRF_idx_out[l] = lane_q[l].p.dest;
            bus.rob_idx_out[l]      = lane_q[l].p.rob;
            bus.PC_out[l]           = lane_q[l].p.pc;
            bus.Operation_out[l]    = lane_q[l].p.op;
            bus.offset_out[l]       = lane_q[l].p.offset;
            bus.rd_mem_out[l]       = lane_q[l].p.rd_mem;
            bus.wr_mem_out[l]       = lane_q[l].p.wr_mem;
        end
    end

    assign bus.num_is_free = free_cnt;
endmodule

// File: tb/tb_rs_multi.sv
// tb_rs_multi: bench for rs_multi. A queue-based reference model predicts the
// station contents and issued lanes every cycle; a vector table and hand-written
// sequences cover the directed scenarios.
module tb_rs_multi;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned PRF   = 64;
    localparam int unsigned PW    = 6;
    localparam int unsigned ROB   = 16;
    localparam int unsigned RW    = 4;
    localparam int unsigned RS    = 16;
    localparam int unsigned WAYS  = 3;
    localparam int unsigned OLEN  = 16;
    localparam int unsigned PCLEN = 32;
    localparam int unsigned FW    = 5;
    localparam int unsigned CW    = 5;
    localparam int          AGE_MAX = RS - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pc_seq = 0;

    always #5 clock = ~clock;

    rs_multi_if #(.XLEN(XLEN), .PW(PW), .RW(RW), .OLEN(OLEN), .PCLEN(PCLEN), .FW(FW),
                  .WAYS(WAYS), .CW(CW)) bus ();

    rs_multi #(.XLEN(XLEN), .PRF(PRF), .ROB(ROB), .RS(RS), .WAYS(WAYS), .OLEN(OLEN),
               .PCLEN(PCLEN), .FW(FW)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        bit              valid;
        bit              ardy;
        bit              brdy;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [PW-1:0]   dest;
        logic [RW-1:0]   rob;
        logic [OLEN-1:0] off;
        logic [PCLEN-1:0] pc;
        logic [FW-1:0]   op;
        bit              rd;
        bit              wr;
        int              age;
    } ment_t;

    ment_t m        [RS];
    ment_t exp_lane [WAYS];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one clock edge of the station from the spec's rules.
    task automatic model_step();
        int    q[$];
        int    fr[$];
        int    idx;
        ment_t nm [RS];
        ment_t z;
        z = '{default: '0};
        for (int l = 0; l < WAYS; l++) exp_lane[l] = z;
        if (reset || bus.squash) begin
            for (int i = 0; i < RS; i++) m[i] = z;
            return;
        end
        nm = m;
        // Ready candidates ranked by sort key: oldest first, then lowest index.
        for (int i = 0; i < RS; i++) begin
            if (m[i].valid && m[i].ardy && m[i].brdy) begin
`ifdef RS_AGE_SELECT_EN
                q.push_back((AGE_MAX - m[i].age) * RS + i);
`else
                q.push_back(i);
`endif
            end
        end
        q.sort();
        for (int l = WAYS - 1; l >= 0; l--) begin
            if (bus.issue_en[l] && q.size() > 0) begin
                idx = q.pop_front() % RS;
                exp_lane[l] = m[idx];
                exp_lane[l].valid = 1'b1;
                nm[idx].valid = 1'b0;
            end
        end
        for (int i = 0; i < RS; i++) begin
            if (nm[i].valid) begin
                for (int c = 0; c < WAYS; c++) begin
                    if (bus.CDB_valid[c] && !m[i].ardy && m[i].a[PW-1:0] == bus.CDB_PRF_idx[c]) begin
                        nm[i].a = bus.CDB_Data[c]; nm[i].ardy = 1'b1;
                    end
                    if (bus.CDB_valid[c] && !m[i].brdy && m[i].b[PW-1:0] == bus.CDB_PRF_idx[c]) begin
                        nm[i].b = bus.CDB_Data[c]; nm[i].brdy = 1'b1;
                    end
                end
                nm[i].age = (m[i].age < AGE_MAX) ? m[i].age + 1 : AGE_MAX;
            end
        end
        for (int i = 0; i < RS; i++) if (!m[i].valid) fr.push_back(i);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (bus.load_in[w] && fr.size() > 0) begin
                idx = fr.pop_front();
                nm[idx].valid = 1'b1;
                nm[idx].a = bus.opa_in[w];  nm[idx].ardy = bus.opa_valid[w];
                nm[idx].b = bus.opb_in[w];  nm[idx].brdy = bus.opb_valid[w];
                for (int c = 0; c < WAYS; c++) begin
                    if (bus.CDB_valid[c] && !bus.opa_valid[w] &&
                        bus.opa_in[w][PW-1:0] == bus.CDB_PRF_idx[c]) begin
                        nm[idx].a = bus.CDB_Data[c]; nm[idx].ardy = 1'b1;
                    end
                    if (bus.CDB_valid[c] && !bus.opb_valid[w] &&
                        bus.opb_in[w][PW-1:0] == bus.CDB_PRF_idx[c]) begin
                        nm[idx].b = bus.CDB_Data[c]; nm[idx].brdy = 1'b1;
                    end
                end
                nm[idx].dest = bus.dest_PRF_idx_in[w];
                nm[idx].rob  = bus.rob_idx_in[w];
                nm[idx].off  = bus.offset_in[w];
                nm[idx].pc   = bus.PC_in[w];
                nm[idx].op   = bus.Operation_in[w];
                nm[idx].rd   = bus.rd_mem_in[w];
                nm[idx].wr   = bus.wr_mem_in[w];
                nm[idx].age  = 0;
            end
        end
        m = nm;
    endtask

    // One clock: predict, clock, then compare the registered outputs.
    task automatic step();
        int nfree;
        model_step();
        @(posedge clock);
        #1;
        nfree = 0;
        for (int i = 0; i < RS; i++) if (!m[i].valid) nfree++;
        chk("num_is_free", 64'(bus.num_is_free), 64'(nfree));
        for (int l = 0; l < WAYS; l++) begin
            chk($sformatf("inst_out_valid[%0d]", l), 64'(bus.inst_out_valid[l]),
                64'(exp_lane[l].valid));
            if (exp_lane[l].valid && bus.inst_out_valid[l]) begin
                chk($sformatf("opa_out[%0d]", l), bus.opa_out[l], exp_lane[l].a);
                chk($sformatf("opb_out[%0d]", l), bus.opb_out[l], exp_lane[l].b);
                chk($sformatf("dest_out[%0d]", l), 64'(bus.dest_PRF_idx_out[l]), 64'(exp_lane[l].dest));
                chk($sformatf("rob_out[%0d]", l), 64'(bus.rob_idx_out[l]), 64'(exp_lane[l].rob));
                chk($sformatf("pc_out[%0d]", l), 64'(bus.PC_out[l]), 64'(exp_lane[l].pc));
                chk($sformatf("op_out[%0d]", l), 64'(bus.Operation_out[l]), 64'(exp_lane[l].op));
                chk($sformatf("off_out[%0d]", l), 64'(bus.offset_out[l]), 64'(exp_lane[l].off));
                chk($sformatf("mem_out[%0d]", l), 64'({bus.rd_mem_out[l], bus.wr_mem_out[l]}),
                    64'({exp_lane[l].rd, exp_lane[l].wr}));
            end
        end
    endtask

    // Benign defaults with a random payload; callers override what they need.
    task automatic drive_defaults();
        bus.squash    = 1'b0;
        bus.load_in   = '0;
        bus.CDB_valid = '0;
        bus.issue_en  = '0;
        bus.opa_valid = '1;
        bus.opb_valid = '1;
        for (int w = 0; w < WAYS; w++) begin
            bus.opa_in[w]          = {$urandom, $urandom};
            bus.opb_in[w]          = {$urandom, $urandom};
            bus.CDB_Data[w]        = {$urandom, $urandom};
            bus.CDB_PRF_idx[w]     = PW'($urandom);
            bus.dest_PRF_idx_in[w] = PW'($urandom);
            bus.rob_idx_in[w]      = RW'($urandom);
            bus.offset_in[w]       = OLEN'($urandom);
            bus.PC_in[w]           = PCLEN'(pc_seq);
            bus.Operation_in[w]    = FW'($urandom);
            bus.rd_mem_in[w]       = 1'($urandom);
            bus.wr_mem_in[w]       = 1'($urandom);
            pc_seq++;
        end
    endtask

    task automatic reset_dut();
        drive_defaults();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        bit              sq;
        bit [2:0]        load;
        bit [2:0]        av;
        logic [XLEN-1:0] a [WAYS];
        int              clane;
        logic [PW-1:0]   ctag;
        logic [XLEN-1:0] cdata;
        bit [2:0]        ie;
        bit [2:0]        exp_v;
        int              exp_free;
        logic [XLEN-1:0] exp_a2;
    } vec_t;

    function automatic vec_t mk(bit sq, bit [2:0] load, bit [2:0] av, logic [XLEN-1:0] a2,
                                logic [XLEN-1:0] a1, logic [XLEN-1:0] a0, int clane,
                                logic [PW-1:0] ctag, logic [XLEN-1:0] cdata, bit [2:0] ie,
                                bit [2:0] ev, int ef, logic [XLEN-1:0] ea2);
        vec_t v;
        v.sq = sq; v.load = load; v.av = av;
        v.a[2] = a2; v.a[1] = a1; v.a[0] = a0;
        v.clane = clane; v.ctag = ctag; v.cdata = cdata;
        v.ie = ie; v.exp_v = ev; v.exp_free = ef; v.exp_a2 = ea2;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t  vecs [13];
        int    issued;
        logic [RW-1:0] e2;
        logic [RW-1:0] e0;

        // Reset state.
        reset_dut();
        for (int l = 0; l < WAYS; l++) begin
            chk("reset opa_out", bus.opa_out[l], 64'h0);
            chk("reset rob_out", 64'(bus.rob_idx_out[l]), 64'h0);
        end
        chk("reset inst_out_valid", 64'(bus.inst_out_valid), 64'h0);
        chk("reset num_is_free", 64'(bus.num_is_free), 64'd16);

        vecs[0]  = mk(0, 3'b111, 3'b111, 64'h22, 64'h11, 64'h10, -1, 6'd0, 64'h0,
                      3'b111, 3'b000, 13, 64'h0);
        vecs[1]  = mk(0, 3'b000, 3'b111, 64'h0, 64'h0, 64'h0, -1, 6'd0, 64'h0,
                      3'b111, 3'b111, 16, 64'h22);
        vecs[2]  = mk(0, 3'b001, 3'b000, 64'h0, 64'h0, 64'd5, -1, 6'd0, 64'h0,
                      3'b111, 3'b000, 15, 64'h0);
        vecs[3]  = mk(0, 3'b000, 3'b111, 64'h0, 64'h0, 64'h0, 1, 6'd5, 64'hABCD,
                      3'b111, 3'b000, 15, 64'h0);
        vecs[4]  = mk(0, 3'b000, 3'b111, 64'h0, 64'h0, 64'h0, -1, 6'd0, 64'h0,
                      3'b111, 3'b100, 16, 64'hABCD);
        vecs[5]  = mk(0, 3'b001, 3'b000, 64'h0, 64'h0, 64'd9, 2, 6'd9, 64'h1234,
                      3'b111, 3'b000, 15, 64'h0);
        vecs[6]  = mk(0, 3'b000, 3'b111, 64'h0, 64'h0, 64'h0, -1, 6'd0, 64'h0,
                      3'b111, 3'b100, 16, 64'h1234);
        vecs[7]  = mk(0, 3'b111, 3'b111, 64'h1, 64'h2, 64'h3, -1, 6'd0, 64'h0,
                      3'b000, 3'b000, 13, 64'h0);
        vecs[8]  = mk(1, 3'b111, 3'b111, 64'h4, 64'h5, 64'h6, 0, 6'd7, 64'h55,
                      3'b111, 3'b000, 16, 64'h0);
        vecs[9]  = mk(0, 3'b000, 3'b111, 64'h0, 64'h0, 64'h0, -1, 6'd0, 64'h0,
                      3'b111, 3'b000, 16, 64'h0);
        vecs[10] = mk(0, 3'b111, 3'b111, 64'h77, 64'h66, 64'h65, -1, 6'd0, 64'h0,
                      3'b000, 3'b000, 13, 64'h0);
        vecs[11] = mk(0, 3'b000, 3'b111, 64'h0, 64'h0, 64'h0, -1, 6'd0, 64'h0,
                      3'b111, 3'b111, 16, 64'h77);
        vecs[12] = mk(1, 3'b000, 3'b111, 64'h0, 64'h0, 64'h0, -1, 6'd0, 64'h0,
                      3'b111, 3'b000, 16, 64'h0);

        foreach (vecs[k]) begin
            drive_defaults();
            bus.squash    = vecs[k].sq;
            bus.load_in   = vecs[k].load;
            bus.opa_valid = vecs[k].av;
            for (int w = 0; w < WAYS; w++) bus.opa_in[w] = vecs[k].a[w];
            if (vecs[k].clane >= 0) begin
                bus.CDB_valid[vecs[k].clane]   = 1'b1;
                bus.CDB_PRF_idx[vecs[k].clane] = vecs[k].ctag;
                bus.CDB_Data[vecs[k].clane]    = vecs[k].cdata;
            end
            bus.issue_en = vecs[k].ie;
            step();
            chk($sformatf("vec%0d valid", k), 64'(bus.inst_out_valid), 64'(vecs[k].exp_v));
            chk($sformatf("vec%0d free", k), 64'(bus.num_is_free), 64'(vecs[k].exp_free));
            if (vecs[k].exp_v[2]) chk($sformatf("vec%0d opa_out[2]", k), bus.opa_out[2],
                                      vecs[k].exp_a2);
        end

        // Fill to full with waiting operands; extra loads must be dropped.
        reset_dut();
        for (int c = 0; c < 8; c++) begin
            drive_defaults();
            bus.load_in   = '1;
            bus.opa_valid = '0;
            for (int w = 0; w < WAYS; w++) bus.opa_in[w] = 64'd63;
            step();
        end
        chk("full num_is_free", 64'(bus.num_is_free), 64'h0);
        drive_defaults();
        bus.CDB_valid      = 3'b001;
        bus.CDB_PRF_idx[0] = 6'd63;
        bus.CDB_Data[0]    = 64'hF00D;
        step();
        issued = 0;
        for (int c = 0; c < 7; c++) begin
            drive_defaults();
            bus.issue_en = '1;
            step();
            issued += $countones(bus.inst_out_valid);
        end
        chk("drain issued count", 64'(issued), 64'd16);
        chk("drain num_is_free", 64'(bus.num_is_free), 64'd16);

        // Five ready entries with younger ones in the low slots, then issue_en = 101.
        reset_dut();
        drive_defaults(); bus.load_in = 3'b111;
        for (int w = 0; w < WAYS; w++) bus.rob_idx_in[w] = RW'(w);
        step();
        drive_defaults(); bus.load_in = 3'b011;
        for (int w = 0; w < WAYS; w++) bus.rob_idx_in[w] = RW'(4 + w);
        step();
        drive_defaults(); bus.issue_en = 3'b110;
        step();
        drive_defaults(); bus.load_in = 3'b011;
        for (int w = 0; w < WAYS; w++) bus.rob_idx_in[w] = RW'(8 + w);
        step();
        drive_defaults(); bus.issue_en = 3'b101;
        step();
`ifdef RS_AGE_SELECT_EN
        e2 = 4'd0; e0 = 4'd5;
`else
        e2 = 4'd9; e0 = 4'd8;
`endif
        chk("sel valid", 64'(bus.inst_out_valid), 64'b101);
        chk("sel lane2 rob", 64'(bus.rob_idx_out[2]), 64'(e2));
        chk("sel lane0 rob", 64'(bus.rob_idx_out[0]), 64'(e0));

        // Random traffic against the model.
        reset_dut();
        for (int c = 0; c < 3000; c++) begin
            int base;
            drive_defaults();
            bus.load_in   = 3'($urandom);
            bus.opa_valid = 3'($urandom | $urandom);
            bus.opb_valid = 3'($urandom | $urandom);
            for (int w = 0; w < WAYS; w++) begin
                if (!bus.opa_valid[w]) bus.opa_in[w][PW-1:0] = PW'($urandom_range(0, 7));
                if (!bus.opb_valid[w]) bus.opb_in[w][PW-1:0] = PW'($urandom_range(0, 7));
            end
            base = int'($urandom_range(0, 7));
            for (int w = 0; w < WAYS; w++) bus.CDB_PRF_idx[w] = PW'((base + w) % 8);
            bus.CDB_valid = 3'($urandom);
            bus.issue_en  = 3'($urandom);
            bus.squash    = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
